// File: rtl/viterbi_hard_decoder.sv
// viterbi_hard_decoder
//   Hard-decision Viterbi decoder, K=7, rate 1/2, g0=133 g1=171 (octal).
//   Serial coded bits are paired into (A,B) symbols; each completed pair runs
//   one add-compare-select step over all 64 states. Survivors are kept by
//   register exchange and decoded bits leave serially, one per trellis step.
//
// Parameters
//   TB_DEPTH  survivor length in steps (>= 8); also the decode latency in steps
//   PM_WIDTH  path-metric width (>= 6)
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous, active-high reset
//   Input        coded bit, A first then B of each pair
//   InputValid   Input qualifier; gaps of any length allowed
//   Output       decoded information bit
//   OutputValid  one-cycle strobe qualifying Output
//
// Build option
//   VITERBI_BEST_STATE_EN  when defined, decode from the minimum-metric state
//                          (64-way compare tree, lowest index on ties);
//                          otherwise decode from state 0.

// One ACS cell. STATE fixes the expected code pairs at elaboration time.
module viterbi_acs #(
   parameter int PM_WIDTH = 8,
   parameter int TB_DEPTH = 36,
   parameter int STATE    = 0
) (
   input  logic                a,
   input  logic                b,
   input  logic [PM_WIDTH-1:0] pm_p0,
   input  logic [PM_WIDTH-1:0] pm_p1,
   input  logic [TB_DEPTH-2:0] surv_p0,
   input  logic [TB_DEPTH-2:0] surv_p1,
   output logic [PM_WIDTH-1:0] pm_new,
   output logic [TB_DEPTH-1:0] surv_new
);
   localparam logic [5:0] ST   = 6'(STATE);
   localparam logic       DBIT = ST[5];
   // Encoder vector {in, d1..d6} for the transitions p0->STATE and p1->STATE
   localparam logic [6:0] V0  = {DBIT, ST[4:0], 1'b0};
   localparam logic [6:0] V1  = {DBIT, ST[4:0], 1'b1};
   localparam logic [6:0] G0  = 7'b1011011;
   localparam logic [6:0] G1  = 7'b1111001;
   localparam logic       EA0 = ^(V0 & G0);
   localparam logic       EB0 = ^(V0 & G1);
   localparam logic       EA1 = ^(V1 & G0);
   localparam logic       EB1 = ^(V1 & G1);

   logic [1:0]          bm0, bm1;
   logic [PM_WIDTH-1:0] c0, c1;

   always_comb begin
      bm0 = {1'b0, a ^ EA0} + {1'b0, b ^ EB0};
      bm1 = {1'b0, a ^ EA1} + {1'b0, b ^ EB1};
      c0  = pm_p0 + PM_WIDTH'(bm0);
      c1  = pm_p1 + PM_WIDTH'(bm1);
      // strict compare: p0 wins ties
      if (c1 < c0) begin
         pm_new   = c1;
         surv_new = {surv_p1, DBIT};
      end else begin
         pm_new   = c0;
         surv_new = {surv_p0, DBIT};
      end
   end
endmodule

module viterbi_hard_decoder #(
   parameter int TB_DEPTH = 36,
   parameter int PM_WIDTH = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Input,
   input  logic InputValid,
   output logic Output,
   output logic OutputValid
);
   localparam int NS     = 64;
   localparam int FILL_W = $clog2(TB_DEPTH + 1);
   localparam logic [PM_WIDTH-1:0] PM_INIT = PM_WIDTH'(1) << (PM_WIDTH - 2);

   logic                             phase, a_q, step, step_q, norm, full;
   logic [NS-1:0][PM_WIDTH-1:0]      pm, pm_nxt;
   logic [NS-1:0][TB_DEPTH-1:0]      surv, surv_nxt;
   logic [NS-1:0]                    msb;
   logic [FILL_W-1:0]                fill;
   logic [5:0]                       sel;

   // B bit of a pair arrives while phase=1: ACS fires on that edge
   assign step = InputValid & phase;
   assign full = (fill == FILL_W'(TB_DEPTH));

   for (genvar n = 0; n < NS; n++) begin : g_acs
      localparam int P0 = (n % 32) * 2;
      viterbi_acs #(.PM_WIDTH(PM_WIDTH), .TB_DEPTH(TB_DEPTH), .STATE(n)) u_acs (
         .a        (a_q),
         .b        (Input),
         .pm_p0    (pm[P0]),
         .pm_p1    (pm[P0+1]),
         .surv_p0  (surv[P0][TB_DEPTH-2:0]),
         .surv_p1  (surv[P0+1][TB_DEPTH-2:0]),
         .pm_new   (pm_nxt[n]),
         .surv_new (surv_nxt[n])
      );
      assign msb[n] = pm_nxt[n][PM_WIDTH-1];
   end

   // Metrics only grow; once every one has its MSB set, dropping the MSB is a
   // uniform subtraction that keeps all comparisons intact.
   assign norm = &msb;

`ifdef VITERBI_BEST_STATE_EN
   // Registered metrics are the post-step values when the decode is taken.
   // Tree reduction in place; left (lower index) wins ties at every node.
   logic [PM_WIDTH-1:0] lv_pm [NS];
   logic [5:0]          lv_ix [NS];
   always_comb begin
      for (int i = 0; i < NS; i++) begin
         lv_pm[i] = pm[i];
         lv_ix[i] = 6'(i);
      end
      for (int w = NS / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            if (lv_pm[2*i+1] < lv_pm[2*i]) begin
               lv_pm[i] = lv_pm[2*i+1];
               lv_ix[i] = lv_ix[2*i+1];
            end else begin
               lv_pm[i] = lv_pm[2*i];
               lv_ix[i] = lv_ix[2*i];
            end
         end
      end
      sel = lv_ix[0];
   end
`else
   assign sel = '0;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         phase       <= 1'b0;
         a_q         <= 1'b0;
         for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
         surv        <= '0;
         fill        <= '0;
         step_q      <= 1'b0;
         Output      <= 1'b0;
         OutputValid <= 1'b0;
      end else begin
         if (InputValid) begin
            phase <= ~phase;
            if (!phase) a_q <= Input;
         end
         if (step) begin
            for (int i = 0; i < NS; i++)
               pm[i] <= {pm_nxt[i][PM_WIDTH-1] & ~norm, pm_nxt[i][PM_WIDTH-2:0]};
            surv <= surv_nxt;
            if (!full) fill <= fill + FILL_W'(1);
         end
         // Decode one cycle after the step, from the updated survivors
         step_q      <= step;
         OutputValid <= step_q & full;
         if (step_q & full) Output <= surv[sel][TB_DEPTH-1];
      end
   end
endmodule

// File: doc/viterbi_hard_decoder.md
# viterbi_hard_decoder

Hard-decision Viterbi decoder for the 802.11a receiver: K=7, rate-1/2, generators g0=133 and g1=171 (octal). It sits directly downstream of the deinterleaver (and any depuncturer). It consumes the deinterleaved serial coded-bit stream one bit per valid cycle, pairs the bits into (A,B) code symbols, and performs one add-compare-select (ACS) step per pair over 64 states. Survivor paths use register exchange; decoded bits are emitted serially, toward the descrambler.

## Interface
- TB_DEPTH, 36: survivor length in trellis steps; this is also the decode latency in steps. Minimum value 8.
- PM_WIDTH, 8: path-metric width in bits. Minimum value 6.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Input  input  1  coded bit, sampled when InputValid=1. Order within a pair: A (g0) first, then B (g1).
- InputValid  input  1  Input is valid this cycle; gaps of any length are allowed.
- Output  output  1  decoded information bit.
- OutputValid  output  1  one-cycle strobe qualifying Output.

## Operation
- Encoder model: vector {in, d1..d6}, where d1 is the most recent previous bit.
  - g0 = 1011011 and g1 = 1111001 over that vector (MSB = in).
  - State s = {d1..d6}, with d1 in bit 5. Next state = {in, s[5:1]}.
- Pairing: a phase flag toggles on each valid bit.
  - Phase 0 latches A.
  - Phase 1 completes the pair and triggers one ACS step on that same edge.
- Branch metric: Hamming distance between the received (A,B) and the expected pair, range 0..2.
- ACS for each state n:
  - Predecessors are p0 = {n[4:0],0} and p1 = {n[4:0],1}; the decided bit is n[5].
  - Candidate metric = PM[p] + BM(p→n). The smaller candidate wins; on a tie, p0 wins.
  - New survivor = {survivor[p][TB_DEPTH-2:0], n[5]}.
- Normalization: if every new metric has its MSB set, clear that MSB in all 64 metrics in the same step. No metric ever saturates or wraps.
- Decision:
  - The decoded bit is survivor[sel][TB_DEPTH-1].
  - sel is chosen per the Configuration section.
- Fill counter: saturates at TB_DEPTH. The output strobe is suppressed until TB_DEPTH ACS steps have completed. The decoded bit of step k is emitted at step k+TB_DEPTH-1.
- No flush input. To drain the final TB_DEPTH-1 bits, the upstream appends TB_DEPTH-1 all-zero pairs after the 6 tail bits.
- Reset values:
  - PM[0] = 0; all other PM = 2^(PM_WIDTH-2).
  - All survivors 0, phase 0, fill counter 0, Output 0, OutputValid 0.
- Reset mid-packet: everything returns to the reset values immediately, including a half-received pair, which is discarded. No strobe is produced for partial data.

## Timing
- Edge E is the edge that captures the B bit of a pair. PM and survivors update at E.
- Output and OutputValid register on edge E+1 from the post-E survivors. OutputValid is high for exactly one cycle.
- Maximum throughput: one bit per cycle in, one decoded bit per 2 cycles out.
- Latency from the B bit of step k to Output: (TB_DEPTH-1) further steps, plus 1 cycle.
- An InputValid gap stalls the pairing only. The strobe pipeline is unaffected.

## Configuration
- VITERBI_BEST_STATE_EN defined:
  - sel is the state with the minimum new PM, found by a 64-way compare tree.
  - Ties go to the lowest state index.
- Undefined:
  - sel is fixed at state 0, with no compare tree.
  - Correct only when TB_DEPTH ≥ 36, or on zero-terminated data.
- All other behaviour and timing are identical in both builds.

## Test plan
- All-zero input, 100 pairs, InputValid continuous -> first OutputValid on the cycle after pair 36's edge, then 65 strobes, all Output=0.
- Impulse: pairs 11,01,11,11,00,10,11, then zeros -> first decoded bit 1, all following bits 0.
- Random 200 info bits plus 6 tail zeros, encoded, plus 35 zero pairs -> 206 output bits match exactly. Repeat with one flipped coded bit per 20 pairs -> still an exact match.
- InputValid randomly deasserted ~50% of cycles -> identical output bit sequence to the continuous case.
- 5000 random pairs with errors -> normalization exercised: all PM < 2^PM_WIDTH, PM[best] < 2^(PM_WIDTH-1) after each step, no decode mismatch.
- Reset asserted after the A bit of pair 50 -> Output=0, OutputValid=0. After release, the stream restarts at pair 1 and the first strobe comes after 36 new pairs.
